// File: rtl/e_mdu_if.sv
// rtl/e_mdu_if.sv - E-stage multiply/divide unit request/response bundle
interface e_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [3:0]       MDUOp;
    logic [WIDTH-1:0] Src_A;
    logic [WIDTH-1:0] Src_B;
    logic             busy;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;
    logic [WIDTH-1:0] MDUOut;

    modport master (
        output start, MDUOp, Src_A, Src_B,
        input  busy, HI, LO, MDUOut
    );

    modport slave (
        input  start, MDUOp, Src_A, Src_B,
        output busy, HI, LO, MDUOut
    );
endinterface

// File: rtl/e_mdu.sv
// rtl/e_mdu.sv - multi-cycle multiply/divide unit holding architectural HI/LO
module e_mdu #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input logic   clk,
    input logic   reset,
    e_mdu_if.slave mdu
);
    localparam logic [3:0] OP_MULT  = 4'b0000;
    localparam logic [3:0] OP_MULTU = 4'b0001;
    localparam logic [3:0] OP_DIV   = 4'b0010;
    localparam logic [3:0] OP_DIVU  = 4'b0011;
    localparam logic [3:0] OP_MTHI  = 4'b0100;
    localparam logic [3:0] OP_MTLO  = 4'b0101;
    localparam logic [3:0] OP_MFHI  = 4'b0110;
    localparam logic [3:0] OP_MFLO  = 4'b0111;

    localparam logic [7:0] MUL_N = 8'(MUL_CYCLES);
    localparam logic [7:0] DIV_N = 8'(DIV_CYCLES);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [7:0]       count;
    logic             busy_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic             is_signed;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             res_wr;

    // Result of the latched op; division works on magnitudes then restores signs,
    // which makes most-negative / -1 wrap naturally and keeps remainder sign = dividend.
    always_comb begin
        is_signed = ~op_q[0];
        prod      = '0;
        mag_a     = a_q;
        mag_b     = b_q;
        quo       = '0;
        rem       = '0;
        res_hi    = hi_q;
        res_lo    = lo_q;
        res_wr    = 1'b1;
        if (!op_q[1]) begin
            if (is_signed) begin
                prod = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
            end else begin
                prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
            end
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
        end else begin
            if (is_signed && a_q[WIDTH-1]) mag_a = -a_q;
            if (is_signed && b_q[WIDTH-1]) mag_b = -b_q;
            if (b_q == '0) begin
                res_wr = 1'b0;
            end else begin
                quo    = mag_a / mag_b;
                rem    = mag_a % mag_b;
                res_lo = (is_signed && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo : quo;
                res_hi = (is_signed && a_q[WIDTH-1]) ? -rem : rem;
            end
        end
    end

    // Control FSM plus HI/LO storage; all outputs come straight from these registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            count  <= '0;
            busy_q <= 1'b0;
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mdu.start) begin
                        case (mdu.MDUOp)
                            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                                a_q    <= mdu.Src_A;
                                b_q    <= mdu.Src_B;
                                op_q   <= mdu.MDUOp[1:0];
                                count  <= mdu.MDUOp[1] ? DIV_N : MUL_N;
                                busy_q <= 1'b1;
                                state  <= RUN;
                            end
                            OP_MTHI: hi_q <= mdu.Src_A;
                            OP_MTLO: lo_q <= mdu.Src_A;
                            default: ;
                        endcase
                    end
                end
                RUN: begin
                    count <= count - 8'd1;
                    if (count == 8'd1) begin
                        if (res_wr) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                        end
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Move-from read port: decoded purely from the op code and the HI/LO registers.
    always_comb begin
        mdu.MDUOut = '0;
        if (mdu.MDUOp == OP_MFHI) mdu.MDUOut = hi_q;
        else if (mdu.MDUOp == OP_MFLO) mdu.MDUOut = lo_q;
    end

    assign mdu.busy = busy_q;
    assign mdu.HI   = hi_q;
    assign mdu.LO   = lo_q;
endmodule

// File: tb/tb_e_mdu.sv
// tb/tb_e_mdu.sv - randomized self-checking bench for e_mdu with a reference model
module tb_e_mdu;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    e_mdu_if #(.WIDTH(32)) bus32 ();
    e_mdu_if #(.WIDTH(16)) bus16 ();

    e_mdu dut32 (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus32)
    );

    e_mdu #(
        .WIDTH      (16),
        .MUL_CYCLES (1),
        .DIV_CYCLES (1)
    ) dut16 (
        .clk   (clk),
        .reset (reset),
        .mdu   (bus16)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic busy_of(input int inst);
        return (inst == 0) ? bus32.busy : bus16.busy;
    endfunction

    function automatic logic [31:0] hi_of(input int inst);
        return (inst == 0) ? bus32.HI : {16'h0, bus16.HI};
    endfunction

    function automatic logic [31:0] lo_of(input int inst);
        return (inst == 0) ? bus32.LO : {16'h0, bus16.LO};
    endfunction

    function automatic logic [31:0] out_of(input int inst);
        return (inst == 0) ? bus32.MDUOut : {16'h0, bus16.MDUOut};
    endfunction

    task automatic drive(input int inst, input logic s, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (inst == 0) begin
            bus32.start = s; bus32.MDUOp = op; bus32.Src_A = a; bus32.Src_B = b;
        end else begin
            bus16.start = s; bus16.MDUOp = op; bus16.Src_A = a[15:0]; bus16.Src_B = b[15:0];
        end
    endtask

    // Architectural meaning of mult/div computed with 64-bit integer arithmetic.
    task automatic ref_calc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                            input int w, output bit wr, output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] mask;
        longint unsigned ua, ub, up;
        longint sa, sb, p, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'h0, a} & mask;
        ub = {32'h0, b} & mask;
        sa = $signed(ua << (64 - w)) >>> (64 - w);
        sb = $signed(ub << (64 - w)) >>> (64 - w);
        wr = 1'b1; hi = '0; lo = '0;
        case (op)
            4'd0: begin p = sa * sb; lo = 32'(p & mask); hi = 32'((p >>> w) & mask); end
            4'd1: begin up = ua * ub; lo = 32'(up & mask); hi = 32'((up >> w) & mask); end
            4'd2: begin
                if (sb == 0) wr = 1'b0;
                else begin q = sa / sb; r = sa % sb; lo = 32'(q & mask); hi = 32'(r & mask); end
            end
            default: begin
                if (ub == 0) wr = 1'b0;
                else begin lo = 32'(ua / ub); hi = 32'(ua % ub); end
            end
        endcase
    endtask

    task automatic run_op(input int inst, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        logic [31:0] wmask, exp_out, eh, el;
        bit wr;
        int n, n_exp;
        wmask = (inst == 0) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
        drive(inst, 1'b1, op, a, b);
        #1;
        exp_out = (op == 4'd6) ? m_hi[inst] : (op == 4'd7) ? m_lo[inst] : 32'h0;
        check({tag, "_mduout"}, out_of(inst), exp_out);
        tick();
        drive(inst, 1'b0, 4'($urandom), $urandom, $urandom);
        if (op <= 4'd3) begin
            n_exp = (inst == 0) ? (op[1] ? 10 : 5) : 1;
            check({tag, "_busy_rise"}, busy_of(inst), 1'b1);
            n = 0;
            while (busy_of(inst) && n < 300) begin
                n++;
                tick();
            end
            check({tag, "_cycles"}, n, n_exp);
            ref_calc(op, a, b, (inst == 0) ? 32 : 16, wr, eh, el);
            if (wr) begin
                m_hi[inst] = eh;
                m_lo[inst] = el;
            end
        end else begin
            if (op == 4'd4) m_hi[inst] = a & wmask;
            if (op == 4'd5) m_lo[inst] = a & wmask;
            check({tag, "_busy_low"}, busy_of(inst), 1'b0);
        end
        drive(inst, 1'b0, 4'hF, 32'h0, 32'h0);
        check({tag, "_hi"}, hi_of(inst), m_hi[inst]);
        check({tag, "_lo"}, lo_of(inst), m_lo[inst]);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'h0000_8000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int n;
        logic [3:0] op;
        m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
        reset = 1'b0;
        drive(0, 1'b0, 4'd6, 32'h0, 32'h0);
        drive(1, 1'b0, 4'd6, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_busy", bus32.busy, 1'b0);
        check("rst_hi", bus32.HI, 32'h0);
        check("rst_lo", bus32.LO, 32'h0);
        check("rst_mfhi", bus32.MDUOut, 32'h0);
        check("rst16_busy", bus16.busy, 1'b0);
        reset = 1'b1;
        tick();

        // directed cases with explicit architectural values
        run_op(0, 4'd0, 32'hFFFF_FFFE, 32'd3, "mult");
        check("mult_hi_k", bus32.HI, 32'hFFFF_FFFF);
        check("mult_lo_k", bus32.LO, 32'hFFFF_FFFA);
        run_op(0, 4'd1, 32'hFFFF_FFFE, 32'd3, "multu");
        check("multu_hi_k", bus32.HI, 32'h0000_0002);
        check("multu_lo_k", bus32.LO, 32'hFFFF_FFFA);
        run_op(0, 4'd2, 32'hFFFF_FFF9, 32'd2, "div");
        check("div_lo_k", bus32.LO, 32'hFFFF_FFFD);
        check("div_hi_k", bus32.HI, 32'hFFFF_FFFF);
        run_op(0, 4'd3, 32'd7, 32'd2, "divu");
        check("divu_lo_k", bus32.LO, 32'd3);
        check("divu_hi_k", bus32.HI, 32'd1);
        run_op(0, 4'd2, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        check("divovf_lo_k", bus32.LO, 32'h8000_0000);
        check("divovf_hi_k", bus32.HI, 32'h0);

        run_op(0, 4'd4, 32'h11, 32'h0, "mthi");
        run_op(0, 4'd5, 32'h22, 32'h0, "mtlo");
        run_op(0, 4'd3, 32'hDEAD_BEEF, 32'h0, "divz");
        check("divz_hi_k", bus32.HI, 32'h11);
        check("divz_lo_k", bus32.LO, 32'h22);
        run_op(0, 4'd6, 32'h0, 32'h0, "mfhi");
        run_op(0, 4'd7, 32'h0, 32'h0, "mflo");

        // starts during RUN are ignored
        drive(0, 1'b1, 4'd0, 32'd5, 32'd7);
        tick();
        drive(0, 1'b0, 4'hF, 32'h0, 32'h0);
        tick();
        drive(0, 1'b1, 4'd5, 32'h55, 32'h0);
        tick();
        drive(0, 1'b1, 4'd0, 32'd100, 32'd100);
        tick();
        drive(0, 1'b0, 4'hF, 32'h0, 32'h0);
        check("conf_busy", bus32.busy, 1'b1);
        n = 0;
        while (bus32.busy && n < 300) begin
            n++;
            tick();
        end
        check("conf_cycles", n, 2);
        check("conf_hi", bus32.HI, 32'd0);
        check("conf_lo", bus32.LO, 32'd35);
        m_hi[0] = 32'd0; m_lo[0] = 32'd35;

        // back-to-back: run_op drives start in the first cycle busy is low
        run_op(0, 4'd0, 32'd1000, 32'd1000, "b2b_a");
        run_op(0, 4'd3, 32'd1000, 32'd7, "b2b_b");

        // reset during busy cycle 3 of a div
        drive(0, 1'b1, 4'd2, 32'hFFFF_FF9C, 32'd7);
        tick();
        drive(0, 1'b0, 4'hF, 32'h0, 32'h0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("midrst_busy", bus32.busy, 1'b0);
        check("midrst_hi", bus32.HI, 32'h0);
        check("midrst_lo", bus32.LO, 32'h0);
        repeat (12) tick();
        check("midrst_late_hi", bus32.HI, 32'h0);
        check("midrst_late_lo", bus32.LO, 32'h0);
        check("midrst_late_busy", bus32.busy, 1'b0);
        m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;

        for (int i = 0; i < 60; i++) begin
            n = $urandom_range(0, 9);
            op = (n < 8) ? 4'(n) : 4'(8 + $urandom_range(0, 7));
            run_op(0, op, rnd_operand(), rnd_operand(), $sformatf("rnd%0d", i));
        end

        // narrow, single-cycle configuration
        run_op(1, 4'd0, 32'h8000, 32'h8000, "w16_mult");
        check("w16_mult_hi_k", bus16.HI, 16'h4000);
        check("w16_mult_lo_k", bus16.LO, 16'h0000);
        for (int i = 0; i < 30; i++) begin
            n = $urandom_range(0, 9);
            op = (n < 8) ? 4'(n) : 4'(8 + $urandom_range(0, 7));
            run_op(1, op, rnd_operand(), rnd_operand(), $sformatf("w16_rnd%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/e_mdu.md
# e_mdu

Parametrised multiply/divide unit in the Execute stage, beside the ALU. Takes the two E-stage operands and an `MDUOp` code. Multiply and divide run multi-cycle, and `busy` is raised so the hazard unit stalls dependent HI/LO accesses. It also holds the architectural HI/LO registers and serves `mfhi`/`mflo`/`mthi`/`mtlo`.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each `WIDTH` bits.
- `MUL_CYCLES`, 5: busy cycles for `mult`/`multu`; legal range 1–255.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`; legal range 1–255.
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `start`  in  1  qualifies `MDUOp` for one cycle; ignored while `busy`=1.
- `MDUOp`  in  4  0000 `mult`, 0001 `multu`, 0010 `div`, 0011 `divu`, 0100 `mthi`, 0101 `mtlo`, 0110 `mfhi`, 0111 `mflo`; other codes are no-ops.
- `Src_A`  in  WIDTH  operand A (rs).
- `Src_B`  in  WIDTH  operand B (rt).
- `busy`  out  1  multi-cycle operation in flight.
- `HI`  out  WIDTH  architectural HI register.
- `LO`  out  WIDTH  architectural LO register.
- `MDUOut`  out  WIDTH  combinational read data: `HI` for `mfhi`, `LO` for `mflo`, otherwise 0. Does not depend on `start`.

## Operation
- **States:** IDLE, RUN.
- **Reset** (`reset`=0 at an edge): state IDLE, counter 0, `busy`=0, `HI`=0, `LO`=0, latched operands and op cleared. Reset overrides everything, including a RUN in progress; the aborted result is discarded.
- **IDLE + `start` + mult/div op:**
  - latch `Src_A`, `Src_B` and the op;
  - load the counter with `MUL_CYCLES` or `DIV_CYCLES`;
  - go to RUN.
- **IDLE + `start` + `mthi`/`mtlo`:** write `Src_A` into HI or LO at that edge. Stay IDLE, `busy` stays 0.
- **IDLE + `start` + `mfhi`/`mflo`/undefined:** no state change.
- **RUN:** the counter decrements each edge. At the edge where the counter equals 1:
  - write the result to HI/LO;
  - return to IDLE.
- **While in RUN:** `start` of any op is ignored, including `mthi`/`mtlo`. The stall logic must not issue these. `HI`/`LO` keep their old values until the final edge.
- **Results** are computed from the latched operands, so inputs may change freely during RUN.
- **`mult`:** signed 2·WIDTH product; HI = upper WIDTH bits, LO = lower WIDTH bits.
- **`multu`:** same as `mult`, unsigned.
- **`div`:** signed.
  - LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - Most-negative ÷ −1: LO = most-negative (wraps), HI = 0.
- **`divu`:** unsigned quotient/remainder.
- **Divide by zero** (`div` or `divu`, B=0): the full busy period still elapses; HI and LO are left unchanged.
- **Datapath:** may compute the result at RUN entry and hold it. It may instead iterate, provided the final values and cycle count match this spec.

## Timing
- `start` sampled at edge T for mult/div:
  - `busy`=1 during cycles T+1 … T+N, where N = `MUL_CYCLES` or `DIV_CYCLES`;
  - HI/LO written at edge T+N;
  - `busy`=0 and new values visible from cycle T+N+1 onward.
- **Back-to-back:** a new `start` is accepted in the first cycle where `busy`=0, i.e. sampled at edge T+N+1. No dead cycle beyond that.
- **`mthi`/`mtlo`:** one-edge latency; the new value is visible on `HI`/`LO` and `MDUOut` the next cycle.
- **`busy`, `HI`, `LO`:** registered outputs, no combinational path from inputs.
- **`MDUOut`:** combinational from `MDUOp`, `HI` and `LO` only.
- **Stall contract:** external stall logic must stall any HI/LO-touching instruction in E while `busy`=1, or while `start`=1 with a mult/div op.

## Test plan
- **Reset:** drive `reset`=0 for 2 cycles → `busy`=0, `HI`=`LO`=0, `MDUOut`=0 for `MDUOp`=0110.
- **`mult`:**
  - Stimulus: defaults, `Src_A`=0xFFFFFFFE (−2), `Src_B`=3, `start` at edge T.
  - Inputs changed to garbage at T+1.
  - Response: `busy` high for exactly 5 cycles; at T+6, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with `multu`: HI=0x00000002, LO=0xFFFFFFFA.
- **`div`:**
  - −7 ÷ 2: after 10 busy cycles, LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1).
  - `divu` 7 ÷ 2: LO=3, HI=1.
  - 0x80000000 ÷ 0xFFFFFFFF (`div`): LO=0x80000000, HI=0.
- **Divide by zero:**
  - Preset HI=0x11, LO=0x22 via `mthi`/`mtlo`.
  - `divu` X ÷ 0 → `busy` for 10 cycles, then HI=0x11 and LO=0x22 unchanged.
- **Busy conflicts:**
  - During RUN, pulse `start` with `mtlo` 0x55 and with `mult` → both ignored; the final result equals the original op only.
  - `start` asserted in the cycle `busy` falls → accepted, and `busy` re-rises next cycle.
- **Reset mid-RUN:** assert `reset`=0 at busy cycle 3 of a `div` → next cycle `busy`=0, `HI`=`LO`=0, no later write occurs.
- **Parameter sweep:** `WIDTH`=16, `MUL_CYCLES`=1, `DIV_CYCLES`=1 → `busy` high for exactly one cycle. 0x8000 × 0x8000 signed gives HI=0x4000, LO=0x0000.
